apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

Parametrised APB (AMBA 3/4) master that turns a valid/ready command stream into APB transfers across a multi-slave bus and returns one response per command. It generalises the team's fixed-width single-slave APB master with configurable address/data width and slave count, address-decoded PSEL, write strobes, PSLVERR reporting and a wait-state timeout. It sits between an internal command source (CPU bridge, DMA, test sequencer) and the peripheral APB fabric.

## Interface

- ADDR_WIDTH, 8, address width; the top SEL_BITS = $clog2(NUM_SLAVES) bits select the slave.
- DATA_WIDTH, 8, data width; must be a multiple of 8.
- NUM_SLAVES, 4, number of APB slaves; power of two, at least 2.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for pready; 0 disables the timeout.

Ports:

- pclk  in  1  single clock; everything is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept; a command is taken when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  pslverr or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- psel  out  NUM_SLAVES  one-hot slave select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB strobes; forced to 0 on reads.
- prdata  in  NUM_SLAVES*DATA_WIDTH  flattened per-slave read data; slave k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- pready  in  NUM_SLAVES  per-slave ready.
- pslverr  in  NUM_SLAVES  per-slave error.

## Operation

- States:
  - IDLE: no transfer in progress; accepts commands.
  - SETUP: PSEL raised, penable low.
  - ACCESS: penable high, waiting for the selected slave's pready.
- IDLE: cmd_ready = 1 (combinational, forced to 0 while rst is high). When a command is accepted:
  - the address, direction, data and strobe are registered onto paddr, pwrite, pwdata and pstrb;
  - sel_idx = cmd_addr[ADDR_WIDTH-1 -: SEL_BITS] is latched;
  - psel[sel_idx] <= 1, penable <= 0, and the state goes to SETUP.
- SETUP → ACCESS, unconditionally after one cycle; penable <= 1, and the wait counter is cleared.
- ACCESS, at each edge, only pready, pslverr and prdata of the latched sel_idx are sampled:
  - **pready = 1:** psel and penable go to 0 and the state goes to IDLE. rsp_valid <= 1, rsp_err <= pslverr[sel_idx], rsp_timeout <= 0. rsp_rdata <= the slave's prdata for reads, 0 for writes.
  - **pready = 0 with TIMEOUT_CYCLES ≠ 0 and the counter at TIMEOUT_CYCLES-1:** the transfer is aborted. psel and penable go to 0 and the state goes to IDLE. rsp_valid = rsp_err = rsp_timeout = 1 and rsp_rdata = 0.
  - **Otherwise:** the counter increments. paddr, pwrite, pwdata and pstrb stay stable.
- Responses:
  - rsp_valid is a single-cycle pulse with no backpressure.
  - rsp_rdata, rsp_err and rsp_timeout hold their values until the next response.
- Outside a transfer, paddr, pwrite and pwdata hold their last values. pstrb for reads is 0.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and is only meaningful in ACCESS.
- Reset mid-transfer: the transfer is abandoned silently with no rsp_valid, and all outputs are reset.

## Timing

- Reset values:
  - state = IDLE;
  - psel, penable, pwrite, paddr, pwdata, pstrb = 0;
  - rsp_valid, rsp_rdata, rsp_err, rsp_timeout = 0;
  - cmd_ready = 0 while rst is high, and 1 in the first cycle after rst drops.
- Zero-wait-state transfer, with the command accepted at edge E:
  - cycle after E: SETUP (psel = 1, penable = 0);
  - after E+1: ACCESS (penable = 1);
  - pready is sampled at E+2;
  - after E+2: rsp_valid = 1, psel = 0, and cmd_ready = 1.
- Throughput: at most one transfer per 3 cycles. Each wait state adds 1 cycle.
- Timeout with TIMEOUT_CYCLES = T: the abort edge is E+1+T. ACCESS lasts exactly T cycles.
- A new command may be accepted in the same cycle rsp_valid is high.
- psel is never high on more than one bit at a time.
- penable is never high unless psel is non-zero.

## Test plan

- **Single write, zero wait states:** command addr 0x45, data 0xA5, strb 1 (DATA_WIDTH 8, 4 slaves). Required: psel = 0b0010; paddr = 0x45, pwdata = 0xA5, pstrb = 1; SETUP then ACCESS; rsp_valid exactly 3 cycles after acceptance with rsp_err = 0 and rsp_rdata = 0.
- **Read with 2 wait states from slave 3:** addr 0xC0, prdata slice 3 = 0x3C, other slices 0xFF. Required: rsp_rdata = 0x3C, pstrb = 0, and rsp_valid 5 cycles after acceptance.
- **PSLVERR:** slave 0 asserts pslverr together with pready on a write. Required: rsp_err = 1, rsp_timeout = 0, and the next command is accepted in the rsp_valid cycle.
- **Timeout:** TIMEOUT_CYCLES = 4 and pready held low. Required: penable high for exactly 4 cycles, then psel and penable drop, rsp_err = rsp_timeout = 1 and rsp_rdata = 0. With TIMEOUT_CYCLES = 0 the bench holds pready low for 100 cycles and the block must keep waiting.
- **Back-to-back:** cmd_valid held high for 4 mixed read/write commands. Required: cmd_ready pulses only in IDLE; 4 responses arrive in order, each 3 cycles apart; psel stays one-hot throughout.
- **Reset mid-ACCESS:** rst asserted for 1 cycle while waiting. Required: the next cycle shows all outputs 0, no rsp_valid, and cmd_ready = 1 after rst drops.

Source files
------------

// File: rtl/apb_cmd_master.sv
// APB master: valid/ready command stream in, one APB transfer and one response per command out.
// Address-decoded one-hot PSEL across NUM_SLAVES slaves, with an optional wait-state timeout.
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             pclk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int SEL_BITS = $clog2(NUM_SLAVES);
  // Keep the counter at least one bit wide so TIMEOUT_CYCLES = 0 still elaborates.
  localparam int CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TL       = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] T_LAST = CW'(TL);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state;
  logic [SEL_BITS-1:0]   sel_idx;
  logic [CW-1:0]         wait_cnt;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

  assign cmd_ready = (state == IDLE) && !rst;

  always_comb begin
    sel_ready = pready[sel_idx];
    sel_err   = pslverr[sel_idx];
    sel_rdata = prdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= IDLE;
      sel_idx     <= '0;
      wait_cnt    <= '0;
      psel        <= '0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            paddr   <= cmd_addr;
            pwrite  <= cmd_write;
            pwdata  <= cmd_wdata;
            pstrb   <= cmd_write ? cmd_strb : '0;
            sel_idx <= cmd_addr[ADDR_WIDTH-1 -: SEL_BITS];
            psel    <= '0;
            psel[cmd_addr[ADDR_WIDTH-1 -: SEL_BITS]] <= 1'b1;
            penable <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready) begin
            psel        <= '0;
            penable     <= 1'b0;
            state       <= IDLE;
            rsp_valid   <= 1'b1;
            rsp_err     <= sel_err;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= pwrite ? '0 : sel_rdata;
          end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == T_LAST)) begin
            psel        <= '0;
            penable     <= 1'b0;
            state       <= IDLE;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: expected responses are queued at command acceptance
// and compared when rsp_valid appears; a second instance checks the disabled timeout.
module tb_apb_cmd_master;

  localparam int TO = 4;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic        cmd_valid = 1'b0, cmd_valid0 = 1'b0;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr  = '0;
  logic [7:0]  cmd_wdata = '0;
  logic [0:0]  cmd_strb  = '0;
  logic [31:0] prdata    = '0;
  logic [3:0]  pready, pslverr;
  logic [3:0]  pready0  = '0, pslverr0 = '0;

  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, penable, pwrite;
  logic [7:0]  rsp_rdata, paddr, pwdata;
  logic [3:0]  psel;
  logic [0:0]  pstrb;

  logic        cmd_ready0, rsp_valid0, rsp_err0, rsp_timeout0, penable0, pwrite0;
  logic [7:0]  rsp_rdata0, paddr0, pwdata0;
  logic [3:0]  psel0;
  logic [0:0]  pstrb0;

  apb_cmd_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_SLAVES(4), .TIMEOUT_CYCLES(TO)) u_dut (
    .pclk(pclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr));

  apb_cmd_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_SLAVES(4), .TIMEOUT_CYCLES(0)) u_dut0 (
    .pclk(pclk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .rsp_timeout(rsp_timeout0),
    .psel(psel0), .penable(penable0), .pwrite(pwrite0), .paddr(paddr0), .pwdata(pwdata0),
    .pstrb(pstrb0), .prdata(prdata), .pready(pready0), .pslverr(pslverr0));

  always #5 pclk = ~pclk;

  // Slave model: ready after slave_wait ACCESS cycles, never when slave_hang.
  int acc_cnt = 0;
  int slave_wait = 0;
  bit slave_err = 0, slave_hang = 0;
  always @(posedge pclk) acc_cnt <= penable ? acc_cnt + 1 : 0;
  assign pready  = (penable && acc_cnt >= slave_wait && !slave_hang) ? psel : '0;
  assign pslverr = slave_err ? pready : '0;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       to;
    int         due;
  } exp_t;
  exp_t sb[$];

  int pass = 0, total = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic s, input bit keep);
    exp_t e;
    logic [7:0] slice;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    for (int c = 0; c < 50 && !cmd_ready; c++) tick;
    if (!cmd_ready) begin
      total++;
      $display("FAIL accept: cmd_ready got 0 expected 1 within 50 cycles");
    end
    slice   = prdata[a[7:6]*8 +: 8];
    e.rdata = (w || slave_hang) ? 8'h00 : slice;
    e.err   = slave_hang | slave_err;
    e.to    = slave_hang;
    e.due   = cyc + (slave_hang ? 2 + TO : 3 + slave_wait);
    sb.push_back(e);
    tick;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output exp_t e, output bit ok);
    ok = 0;
    e  = '{default: '0};
    for (int k = 0; k < 100 && !rsp_valid; k++) tick;
    if (rsp_valid && sb.size() > 0) begin
      e  = sb.pop_front();
      ok = 1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    total++;
    if ({psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0)
      $display("FAIL reset_outputs: got psel=%b pen=%b paddr=%h rsp_valid=%b expected all 0",
               psel, penable, paddr, rsp_valid);
    else pass++;
    total++;
    if (cmd_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", cmd_ready); else pass++;
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready_after: got %b expected 1", cmd_ready); else pass++;
  endtask

  task automatic test_write;
    exp_t e; bit ok;
    slave_wait = 0; slave_err = 0; slave_hang = 0;
    issue(1'b1, 8'h45, 8'hA5, 1'b1, 1'b0);
    total++;
    if (psel !== 4'b0010 || penable !== 1'b0)
      $display("FAIL wr_setup: got psel=%b pen=%b expected psel=0010 pen=0", psel, penable);
    else pass++;
    total++;
    if (paddr !== 8'h45 || pwdata !== 8'hA5 || pstrb !== 1'b1 || pwrite !== 1'b1)
      $display("FAIL wr_bus: got paddr=%h pwdata=%h pstrb=%b pwrite=%b expected 45 a5 1 1",
               paddr, pwdata, pstrb, pwrite);
    else pass++;
    tick;
    total++;
    if (penable !== 1'b1 || psel !== 4'b0010)
      $display("FAIL wr_access: got psel=%b pen=%b expected psel=0010 pen=1", psel, penable);
    else pass++;
    get_rsp(e, ok);
    total++;
    if (!ok) $display("FAIL wr_rsp: got no response expected rsp_valid");
    else if (cyc !== e.due || rsp_err !== e.err || rsp_rdata !== e.rdata || rsp_timeout !== e.to)
      $display("FAIL wr_rsp: got cyc=%0d err=%b rdata=%h to=%b expected cyc=%0d err=%b rdata=%h to=%b",
               cyc, rsp_err, rsp_rdata, rsp_timeout, e.due, e.err, e.rdata, e.to);
    else pass++;
    total++;
    if (psel !== 4'b0000 || cmd_ready !== 1'b1)
      $display("FAIL wr_done: got psel=%b ready=%b expected 0000 1", psel, cmd_ready);
    else pass++;
  endtask

  task automatic test_read_wait;
    exp_t e; bit ok;
    slave_wait = 2; slave_err = 0; slave_hang = 0;
    prdata = {8'h3C, 8'hFF, 8'hFF, 8'hFF};
    issue(1'b0, 8'hC0, 8'h00, 1'b1, 1'b0);
    total++;
    if (psel !== 4'b1000 || pstrb !== 1'b0 || pwrite !== 1'b0 || paddr !== 8'hC0)
      $display("FAIL rd_setup: got psel=%b pstrb=%b pwrite=%b paddr=%h expected 1000 0 0 c0",
               psel, pstrb, pwrite, paddr);
    else pass++;
    get_rsp(e, ok);
    total++;
    if (!ok) $display("FAIL rd_rsp: got no response expected rsp_valid");
    else if (cyc !== e.due || rsp_rdata !== e.rdata || rsp_err !== e.err)
      $display("FAIL rd_rsp: got cyc=%0d rdata=%h err=%b expected cyc=%0d rdata=%h err=%b",
               cyc, rsp_rdata, rsp_err, e.due, e.rdata, e.err);
    else pass++;
    tick; tick;
    total++;
    if (rsp_rdata !== 8'h3C || rsp_valid !== 1'b0)
      $display("FAIL rd_hold: got rdata=%h valid=%b expected 3c 0", rsp_rdata, rsp_valid);
    else pass++;
    slave_wait = 0;
  endtask

  task automatic test_pslverr;
    exp_t e; bit ok;
    slave_wait = 0; slave_err = 1; slave_hang = 0;
    prdata = {8'h44, 8'h33, 8'h22, 8'h11};
    issue(1'b1, 8'h10, 8'h5A, 1'b1, 1'b0);
    get_rsp(e, ok);
    total++;
    if (!ok) $display("FAIL err_rsp: got no response expected rsp_valid");
    else if (rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || cyc !== e.due)
      $display("FAIL err_rsp: got err=%b to=%b cyc=%0d expected err=1 to=0 cyc=%0d",
               rsp_err, rsp_timeout, cyc, e.due);
    else pass++;
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL err_ready: got %b expected 1 in rsp cycle", cmd_ready);
    else pass++;
    slave_err = 0;
    issue(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    get_rsp(e, ok);
    total++;
    if (!ok) $display("FAIL err_next: got no response expected rsp_valid");
    else if (rsp_err !== 1'b0 || rsp_rdata !== e.rdata || cyc !== e.due)
      $display("FAIL err_next: got err=%b rdata=%h cyc=%0d expected err=0 rdata=%h cyc=%0d",
               rsp_err, rsp_rdata, cyc, e.rdata, e.due);
    else pass++;
  endtask

  task automatic test_timeout;
    exp_t e; bit ok; int pen_cycles;
    slave_wait = 0; slave_err = 0; slave_hang = 1;
    issue(1'b0, 8'h84, 8'h77, 1'b1, 1'b0);
    pen_cycles = 0;
    for (int k = 0; k < 40 && !rsp_valid; k++) begin
      if (penable) pen_cycles++;
      tick;
    end
    get_rsp(e, ok);
    total++;
    if (pen_cycles !== TO) $display("FAIL to_len: got penable cycles=%0d expected %0d", pen_cycles, TO);
    else pass++;
    total++;
    if (!ok) $display("FAIL to_rsp: got no response expected rsp_valid");
    else if (rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 8'h00 || cyc !== e.due)
      $display("FAIL to_rsp: got err=%b to=%b rdata=%h cyc=%0d expected 1 1 00 cyc=%0d",
               rsp_err, rsp_timeout, rsp_rdata, cyc, e.due);
    else pass++;
    total++;
    if (psel !== 4'b0000 || penable !== 1'b0)
      $display("FAIL to_drop: got psel=%b pen=%b expected 0000 0", psel, penable);
    else pass++;
    slave_hang = 0;
  endtask

  task automatic test_no_timeout;
    int seen;
    cmd_write = 1'b0; cmd_addr = 8'h80; cmd_wdata = 8'h00; cmd_strb = 1'b1;
    cmd_valid0 = 1'b1;
    for (int k = 0; k < 10 && !cmd_ready0; k++) tick;
    tick;
    cmd_valid0 = 1'b0;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      if (rsp_valid0) seen++;
      tick;
    end
    total++;
    if (seen !== 0 || penable0 !== 1'b1 || psel0 !== 4'b0100)
      $display("FAIL notimeout: got rsp=%0d pen=%b psel=%b expected 0 1 0100", seen, penable0, psel0);
    else pass++;
  endtask

  task automatic test_back_to_back;
    int got, last;
    exp_t e;
    slave_wait = 0; slave_err = 0; slave_hang = 0;
    prdata = {8'h33, 8'h22, 8'h11, 8'h5A};
    got = 0; last = -1;
    fork
      begin
        issue(1'b1, 8'h04, 8'hA1, 1'b1, 1'b1);
        issue(1'b0, 8'h48, 8'hB2, 1'b1, 1'b1);
        issue(1'b1, 8'h8C, 8'hC3, 1'b1, 1'b1);
        issue(1'b0, 8'hC4, 8'hD4, 1'b1, 1'b0);
      end
      begin
        for (int k = 0; k < 60 && got < 4; k++) begin
          total++;
          if ($countones(psel) > 1 || (penable && psel == 4'b0000))
            $display("FAIL b2b_onehot: got psel=%b pen=%b expected one-hot", psel, penable);
          else pass++;
          total++;
          if (cmd_ready && psel != 4'b0000)
            $display("FAIL b2b_ready: got ready=1 psel=%b expected psel=0000", psel);
          else pass++;
          if (rsp_valid) begin
            e = sb.pop_front();
            total++;
            if (rsp_rdata !== e.rdata || rsp_err !== 1'b0 || cyc !== e.due || (last >= 0 && cyc - last != 3))
              $display("FAIL b2b_rsp%0d: got rdata=%h err=%b cyc=%0d last=%0d expected rdata=%h err=0 cyc=%0d",
                       got, rsp_rdata, rsp_err, cyc, last, e.rdata, e.due);
            else pass++;
            last = cyc;
            got++;
          end
          tick;
        end
      end
    join
    total++;
    if (got !== 4) $display("FAIL b2b_count: got %0d responses expected 4", got); else pass++;
  endtask

  task automatic test_reset_mid;
    int seen;
    slave_wait = 0; slave_err = 0; slave_hang = 1;
    issue(1'b1, 8'h50, 8'h99, 1'b1, 1'b0);
    tick; tick;
    total++;
    if (penable !== 1'b1) $display("FAIL rm_access: got pen=%b expected 1", penable); else pass++;
    rst = 1'b1;
    tick;
    total++;
    if ({psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready} !== '0)
      $display("FAIL rm_outputs: got psel=%b pen=%b paddr=%h pwdata=%h rsp_valid=%b ready=%b expected all 0",
               psel, penable, paddr, pwdata, rsp_valid, cmd_ready);
    else pass++;
    rst = 1'b0;
    void'(sb.pop_back());
    slave_hang = 0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL rm_ready: got %b expected 1", cmd_ready); else pass++;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid) seen++;
      tick;
    end
    total++;
    if (seen !== 0) $display("FAIL rm_norsp: got %0d responses expected 0", seen); else pass++;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read_wait;
    test_pslverr;
    test_timeout;
    test_no_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
